// File: rtl/boot_mem.sv
// Unified byte-addressed instruction/data memory with four combinational read
// ports, one store port, and a byte-stream boot loader that holds the core in reset.
package boot_mem_pkg;
    typedef enum logic [2:0] {
        LDST_WORD,
        LDST_HALF,
        LDST_UHALF,
        LDST_BYTE,
        LDST_UBYTE
    } ldst_mode;
endpackage

// state   | meaning
// ST_LOAD | accepting boot bytes into mem[ptr], core held in reset, stores ignored
// ST_RUN  | core released, stores active, loader ignored until next reset
module boot_mem
    import boot_mem_pkg::*;
#(
    parameter int MEM_BYTES = 65536,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ra [4],
    input  ldst_mode      rm [4],
    output logic [31:0]   rd [4],
    input  logic          we,
    input  logic [31:0]   wa,
    input  logic [31:0]   wd,
    input  ldst_mode      wm,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          core_reset,
    output logic [AW:0]   load_count
);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    state_t        state;
    logic [AW-1:0] ptr;
    logic [7:0]    rbyte [4][4];
    logic [AW-1:0] wbase;
    logic [2:0]    wnum;
    logic          unused_addr_bits;

    // Upper address bits only alias; they carry no information here.
    assign unused_addr_bits = ^{ra[0][31:AW], ra[1][31:AW], ra[2][31:AW],
                                ra[3][31:AW], wa[31:AW]};

    assign ld_ready = (state == ST_LOAD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            load_count <= '0;
            core_reset <= 1'b1;
        end else if (state == ST_LOAD && ld_valid) begin
            ptr <= ptr + AW'(1);
            if (load_count != COUNT_FULL) begin
                load_count <= load_count + (AW+1)'(1);
            end
            if (ld_last) begin
                state      <= ST_RUN;
                core_reset <= 1'b0;
            end
        end
    end

    assign wbase = wa[AW-1:0];

    always_comb begin
        case (wm)
            LDST_HALF, LDST_UHALF: wnum = 3'd2;
            LDST_BYTE, LDST_UBYTE: wnum = 3'd1;
            default:               wnum = 3'd4;
        endcase
    end

    // Memory is not reset; a reset edge suppresses both loader and store writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_LOAD) begin
                if (ld_valid) begin
                    mem[ptr] <= ld_data;
                end
            end else if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) < wnum) begin
                        mem[wbase + AW'(k)] <= wd[8*k +: 8];
                    end
                end
            end
        end
    end

    // Byte lanes wrap naturally through the AW-bit index addition.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                rbyte[p][k] = mem[ra[p][AW-1:0] + AW'(k)];
            end
            case (rm[p])
                LDST_HALF:  rd[p] = {{16{rbyte[p][1][7]}}, rbyte[p][1], rbyte[p][0]};
                LDST_UHALF: rd[p] = {16'h0000, rbyte[p][1], rbyte[p][0]};
                LDST_BYTE:  rd[p] = {{24{rbyte[p][0][7]}}, rbyte[p][0]};
                LDST_UBYTE: rd[p] = {24'h000000, rbyte[p][0]};
                default:    rd[p] = {rbyte[p][3], rbyte[p][2], rbyte[p][1], rbyte[p][0]};
            endcase
        end
    end

endmodule

// File: tb/tb_boot_mem.sv
// Self-checking bench for boot_mem: directed boot/store/wrap/reset scenarios
// followed by randomized traffic compared against a byte-array reference model.
module tb_boot_mem;
    import boot_mem_pkg::*;

    localparam int MEMB = 256;
    localparam int AW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   ra [4];
    ldst_mode      rm [4];
    logic [31:0]   rd [4];
    logic          we;
    logic [31:0]   wa;
    logic [31:0]   wd;
    ldst_mode      wm;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          core_reset;
    logic [AW:0]   load_count;

    always #5 clk = ~clk;

    boot_mem #(.MEM_BYTES(MEMB)) dut (
        .clk        (clk),
        .reset      (reset),
        .ra         (ra),
        .rm         (rm),
        .rd         (rd),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .wm         (wm),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .core_reset (core_reset),
        .load_count (load_count)
    );

    // Reference model: plain byte array plus loader bookkeeping.
    logic [7:0] model_mem [MEMB];
    bit         mload;
    int         mptr;
    int         mcount;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] boot_img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    function automatic int width_of(input ldst_mode m);
        if (m == LDST_HALF || m == LDST_UHALF) return 2;
        if (m == LDST_BYTE || m == LDST_UBYTE) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input ldst_mode m);
        logic [31:0] v = 32'h0;
        int base = int'(a % MEMB);
        for (int k = 0; k < width_of(m); k++) begin
            v = v | (32'(model_mem[(base + k) % MEMB]) << (8 * k));
        end
        if (m == LDST_HALF && v[15]) v = v | 32'hFFFF_0000;
        if (m == LDST_BYTE && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input ldst_mode m);
        int base = int'(a % MEMB);
        for (int k = 0; k < width_of(m); k++) begin
            model_mem[(base + k) % MEMB] = d[8*k +: 8];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag);
        check({tag, "_core_reset"}, 32'(core_reset), 32'(mload));
        check({tag, "_ld_ready"},   32'(ld_ready),   32'(mload));
        check({tag, "_load_count"}, 32'(load_count), 32'(mcount));
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step;
        reset  = 1'b1;
        mload  = 1'b1;
        mptr   = 0;
        mcount = 0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        step;
        if (mload) begin
            model_mem[mptr] = data;
            mptr   = (mptr + 1) % MEMB;
            mcount = (mcount < MEMB) ? mcount + 1 : MEMB;
            if (last) mload = 1'b0;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input ldst_mode m);
        we = 1'b1;
        wa = a;
        wd = d;
        wm = m;
        step;
        if (!mload) mwrite(a, d, m);
        we = 1'b0;
    endtask

    task automatic read_port(input int p, input logic [31:0] a, input ldst_mode m);
        ra[p] = a;
        rm[p] = m;
        #1;
    endtask

    task automatic check_read(input string tag, input int p, input logic [31:0] a,
                              input ldst_mode m);
        read_port(p, a, m);
        check(tag, rd[p], mread(a, m));
    endtask

    initial begin
        reset    = 1'b0;
        we       = 1'b0;
        wa       = 32'h0;
        wd       = 32'h0;
        wm       = LDST_WORD;
        ld_valid = 1'b0;
        ld_data  = 8'h0;
        ld_last  = 1'b0;
        for (int p = 0; p < 4; p++) begin
            ra[p] = 32'h0;
            rm[p] = LDST_WORD;
        end
        mload  = 1'b1;
        mptr   = 0;
        mcount = 0;
        step;
        step;
        reset = 1'b1;
        check_ctrl("reset");

        // Overfill by four bytes: pointer wraps, count saturates.
        for (int i = 0; i < MEMB + 4; i++) begin
            send_byte(8'($urandom), (i == MEMB + 3));
        end
        check_ctrl("overflow");
        for (int i = 0; i < 8; i++) begin
            check_read("image_read", i % 4, $urandom, ldst_mode'($urandom_range(0, 4)));
        end

        // Directed boot from RUN back through reset, with an ignored store pending.
        do_reset;
        check_ctrl("reset_from_run");
        we = 1'b1;
        wa = 32'h80;
        wd = 32'h1234_5678;
        wm = LDST_WORD;
        for (int i = 0; i < 8; i++) begin
            send_byte(boot_img[i], (i == 7));
            check_ctrl("boot");
        end
        we = 1'b0;
        read_port(0, 32'h0, LDST_WORD);
        check("boot_word0", rd[0], 32'h0010_0513);
        read_port(1, 32'h4, LDST_WORD);
        check("boot_word4", rd[1], 32'hDEAD_BEEF);
        check_read("ignored_store", 2, 32'h80, LDST_WORD);

        send_byte(8'h5A, 1'b1);
        check_ctrl("run_ld_ignored");
        check_read("run_ld_mem", 3, 32'h8, LDST_UBYTE);

        store(32'h9, 32'hFFFF_FF80, LDST_BYTE);
        store(32'hA, 32'h1234_8001, LDST_HALF);
        ra[2] = 32'h9; rm[2] = LDST_BYTE;
        ra[3] = 32'h9; rm[3] = LDST_UBYTE;
        #1;
        check("ext_byte",  rd[2], 32'hFFFF_FF80);
        check("ext_ubyte", rd[3], 32'h0000_0080);
        ra[2] = 32'hA; rm[2] = LDST_HALF;
        ra[3] = 32'hA; rm[3] = LDST_UHALF;
        #1;
        check("ext_half",  rd[2], 32'hFFFF_8001);
        check("ext_uhalf", rd[3], 32'h0000_8001);

        store(32'h20, 32'h1122_3344, LDST_WORD);
        store(32'h21, 32'h1234_56AA, LDST_BYTE);
        store(32'h22, 32'h5555_BEEF, LDST_HALF);
        read_port(0, 32'h20, LDST_WORD);
        check("store_widths", rd[0], 32'hBEEF_AA44);

        store(32'h40, 32'h0, LDST_WORD);
        ra[2] = 32'h40; rm[2] = LDST_WORD;
        ra[3] = 32'h40; rm[3] = LDST_WORD;
        we = 1'b1; wa = 32'h40; wd = 32'hCAFE_F00D; wm = LDST_WORD;
        #1;
        check("rdw_before", rd[2], 32'h0);
        step;
        mwrite(32'h40, 32'hCAFE_F00D, LDST_WORD);
        we = 1'b0;
        #1;
        check("rdw_after",      rd[2], 32'hCAFE_F00D);
        check("rdw_same_bytes", rd[3], 32'hCAFE_F00D);

        store(32'(MEMB - 2), 32'h4433_2211, LDST_WORD);
        read_port(0, 32'(2 * MEMB - 2), LDST_WORD);
        check("wrap_alias_word", rd[0], 32'h4433_2211);
        read_port(1, 32'(MEMB - 1), LDST_UBYTE);
        check("wrap_top_byte", rd[1], 32'h22);
        read_port(1, 32'h1, LDST_UBYTE);
        check("wrap_addr1", rd[1], 32'h44);

        // Reset mid-load restarts the stream at address 0; earlier bytes survive.
        do_reset;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        check_ctrl("partial_load");
        do_reset;
        check_ctrl("mid_load_reset");
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b1);
        check_ctrl("reload");
        read_port(0, 32'h0, LDST_UBYTE);
        check("reload_addr0", rd[0], 32'hB1);
        read_port(0, 32'h1, LDST_UBYTE);
        check("reload_addr1", rd[0], 32'hB2);
        read_port(0, 32'h2, LDST_UBYTE);
        check("stale_addr2", rd[0], 32'hA3);

        for (int i = 0; i < 200; i++) begin
            for (int p = 0; p < 4; p++) begin
                ra[p] = $urandom;
                rm[p] = ldst_mode'($urandom_range(0, 4));
            end
            we = 1'($urandom_range(0, 1));
            wa = $urandom;
            wd = $urandom;
            wm = ldst_mode'($urandom_range(0, 4));
            #1;
            for (int p = 0; p < 4; p++) begin
                check("random_read", rd[p], mread(ra[p], rm[p]));
            end
            step;
            if (we && !mload) mwrite(wa, wd, wm);
        end
        we = 1'b0;
        check_ctrl("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
